// File: rtl/hazard_ctrl_pkg.sv
// Shared types and register constants for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle. master = pipeline, slave = hazard_ctrl.
interface hazard_ctrl_if;

    logic        id_valid;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rs;
    logic        id_uses_rt;
    logic        id_branch;
    logic        id_branch_taken;
    logic        id_muldiv;
    logic        id_reads_hilo;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        mem_memread;
    logic [4:0]  mem_rd;

    logic        pc_stall;
    logic        ifid_stall;
    logic        idex_bubble;
    logic        ifid_flush;
    logic        md_start;
    logic        md_busy;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch,
               id_branch_taken, id_muldiv, id_reads_hilo, ex_regwrite,
               ex_memread, ex_rd, mem_memread, mem_rd,
        input  pc_stall, ifid_stall, idex_bubble, ifid_flush, md_start,
               md_busy, stall_cycles, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_branch,
               id_branch_taken, id_muldiv, id_reads_hilo, ex_regwrite,
               ex_memread, ex_rd, mem_memread, mem_rd,
        output pc_stall, ifid_stall, idex_bubble, ifid_flush, md_start,
               md_busy, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// Mul/div busy tracker: IDLE/BUSY FSM with a down-counter of MD_CYCLES busy cycles.
module md_timer
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic busy
);

    localparam int CNT_W = $clog2(MD_CYCLES);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Busy spans exactly MD_CYCLES cycles: load MD_CYCLES-1, leave on reaching 0.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        busy       = 1'b0;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_next = MD_BUSY;
                    cnt_next   = CNT_W'(MD_CYCLES - 1);
                end
            end
            MD_BUSY: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    state_next = MD_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: state_next = MD_IDLE;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use / branch-in-ID stalls, taken-branch flush, mul/div sequencing.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hc
);

    logic md_busy;
    logic load_use, br_ex, br_mem, md_hold;
    logic stall, flush, start;

    function automatic logic reg_match(input logic [4:0] r,
                                       input logic [4:0] rs, input logic uses_rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != REG_ZERO) && ((r == rs && uses_rs) || (r == rt && uses_rt));
    endfunction

    md_timer #(.MD_CYCLES(MD_CYCLES)) u_md_timer (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .busy  (md_busy)
    );

    // Gating with !rst keeps every output low while reset is held.
    always_comb begin
        load_use = hc.ex_memread &&
                   reg_match(hc.ex_rd, hc.id_rs, hc.id_uses_rs, hc.id_rt, hc.id_uses_rt);
        br_ex    = hc.id_branch && hc.ex_regwrite &&
                   reg_match(hc.ex_rd, hc.id_rs, hc.id_uses_rs, hc.id_rt, hc.id_uses_rt);
        br_mem   = hc.id_branch && hc.mem_memread &&
                   reg_match(hc.mem_rd, hc.id_rs, hc.id_uses_rs, hc.id_rt, hc.id_uses_rt);
        md_hold  = md_busy && (hc.id_muldiv || hc.id_reads_hilo);
        stall    = !rst && hc.id_valid && (load_use || br_ex || br_mem || md_hold);
        flush    = !rst && hc.id_valid && hc.id_branch_taken && !stall;
        start    = !rst && hc.id_valid && hc.id_muldiv && !stall;
    end

    assign hc.pc_stall    = stall;
    assign hc.ifid_stall  = stall;
    assign hc.idex_bubble = stall;
    assign hc.ifid_flush  = flush;
    assign hc.md_start    = start;
    assign hc.md_busy     = md_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt, flush_cnt;

    // Saturating event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
            if (flush && flush_cnt != 32'hFFFF_FFFF) flush_cnt <= flush_cnt + 32'd1;
        end
    end

    assign hc.stall_cycles = stall_cnt;
    assign hc.flush_count  = flush_cnt;
`else
    assign hc.stall_cycles = 32'd0;
    assign hc.flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with MD_CYCLES=4; counter checks follow HAZARD_PERF_EN.
module tb_hazard_ctrl;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    hazard_ctrl_if hif ();

    hazard_ctrl #(.MD_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .hc  (hif)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_stall(input string tag, input logic exp);
        chk({tag, ".pc_stall"},    32'(hif.pc_stall),    32'(exp));
        chk({tag, ".ifid_stall"},  32'(hif.ifid_stall),  32'(exp));
        chk({tag, ".idex_bubble"}, 32'(hif.idex_bubble), 32'(exp));
    endtask

    task automatic clr();
        hif.id_valid        = 1'b0;
        hif.id_rs           = 5'd0;
        hif.id_rt           = 5'd0;
        hif.id_uses_rs      = 1'b0;
        hif.id_uses_rt      = 1'b0;
        hif.id_branch       = 1'b0;
        hif.id_branch_taken = 1'b0;
        hif.id_muldiv       = 1'b0;
        hif.id_reads_hilo   = 1'b0;
        hif.ex_regwrite     = 1'b0;
        hif.ex_memread      = 1'b0;
        hif.ex_rd           = 5'd0;
        hif.mem_memread     = 1'b0;
        hif.mem_rd          = 5'd0;
    endtask

    // Each step: new inputs just after the falling edge, checks 1 time unit later.
    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        clr();
        // Reset held: a load-use pattern must still yield all-zero outputs.
        step();
        hif.id_valid = 1'b1; hif.ex_memread = 1'b1; hif.ex_rd = 5'd8;
        hif.id_rs = 5'd8; hif.id_uses_rs = 1'b1; hif.id_muldiv = 1'b1;
        #1;
        chk_stall("rst_gate", 1'b0);
        chk("rst_md_start", 32'(hif.md_start), 32'd0);
        chk("rst_md_busy", 32'(hif.md_busy), 32'd0);
        chk("rst_stall_cycles", hif.stall_cycles, 32'd0);
        rst = 1'b0;

        // Load-use
        step(); clr();
        hif.id_valid = 1'b1; hif.ex_memread = 1'b1; hif.ex_rd = 5'd8;
        hif.id_rs = 5'd8; hif.id_uses_rs = 1'b1;
        #1; chk_stall("lu_rs", 1'b1);
        chk("lu_no_flush", 32'(hif.ifid_flush), 32'd0);
        step(); hif.id_uses_rs = 1'b0;
        #1; chk_stall("lu_unused_rs", 1'b0);
        step(); hif.id_uses_rs = 1'b1; hif.ex_rd = 5'd0; hif.id_rs = 5'd0;
        #1; chk_stall("lu_r0", 1'b0);
        step(); hif.ex_rd = REG_RA; hif.id_rs = 5'd4; hif.id_rt = REG_RA; hif.id_uses_rt = 1'b1;
        #1; chk_stall("lu_rt", 1'b1);
        step(); hif.id_valid = 1'b0;
        #1; chk_stall("lu_invalid", 1'b0);

        // Branch on $9 after a load: two stall cycles, then the taken flush
        step(); clr();
        hif.id_valid = 1'b1; hif.id_branch = 1'b1; hif.id_branch_taken = 1'b1;
        hif.id_rt = 5'd9; hif.id_uses_rt = 1'b1;
        hif.ex_memread = 1'b1; hif.ex_regwrite = 1'b1; hif.ex_rd = 5'd9;
        #1; chk_stall("brld_c1", 1'b1);
        chk("brld_c1_flush", 32'(hif.ifid_flush), 32'd0);
        step();
        hif.ex_memread = 1'b0; hif.ex_regwrite = 1'b0; hif.ex_rd = 5'd0;
        hif.mem_memread = 1'b1; hif.mem_rd = 5'd9;
        #1; chk_stall("brld_c2", 1'b1);
        chk("brld_c2_flush", 32'(hif.ifid_flush), 32'd0);
        step(); hif.mem_memread = 1'b0; hif.mem_rd = 5'd0;
        #1; chk_stall("brld_c3", 1'b0);
        chk("brld_c3_flush", 32'(hif.ifid_flush), 32'd1);

        // Branch on $3 after an ALU op: one stall cycle
        step(); clr();
        hif.id_valid = 1'b1; hif.id_branch = 1'b1; hif.id_rs = 5'd3; hif.id_uses_rs = 1'b1;
        hif.ex_regwrite = 1'b1; hif.ex_rd = 5'd3;
        #1; chk_stall("bralu_c1", 1'b1);
        step(); hif.ex_regwrite = 1'b0; hif.ex_rd = 5'd0; hif.mem_rd = 5'd3;
        #1; chk_stall("bralu_c2", 1'b0);
        chk("bralu_nt_flush", 32'(hif.ifid_flush), 32'd0);
        step(); hif.id_branch = 1'b0; hif.ex_regwrite = 1'b1; hif.ex_rd = 5'd3; hif.mem_rd = 5'd0;
        #1; chk_stall("alu_nobranch", 1'b0);

        // Mul/div: start at t, mfhi at t+1, second div t+2..t+5
        step(); clr();
        hif.id_valid = 1'b1; hif.id_muldiv = 1'b1;
        #1; chk("md_t0_start", 32'(hif.md_start), 32'd1);
        chk("md_t0_busy", 32'(hif.md_busy), 32'd0);
        chk_stall("md_t0", 1'b0);
        step(); hif.id_muldiv = 1'b0; hif.id_reads_hilo = 1'b1;
        #1; chk("md_t1_busy", 32'(hif.md_busy), 32'd1);
        chk_stall("md_t1_mfhi", 1'b1);
        chk("md_t1_start", 32'(hif.md_start), 32'd0);
        step(); hif.id_reads_hilo = 1'b0; hif.id_muldiv = 1'b1;
        #1; chk_stall("md_t2_div", 1'b1);
        chk("md_t2_start", 32'(hif.md_start), 32'd0);
        step();
        #1; chk("md_t3_busy", 32'(hif.md_busy), 32'd1);
        step();
        #1; chk("md_t4_busy", 32'(hif.md_busy), 32'd1);
        chk_stall("md_t4", 1'b1);
        step();
        #1; chk("md_t5_busy", 32'(hif.md_busy), 32'd0);
        chk_stall("md_t5", 1'b0);
        chk("md_t5_start", 32'(hif.md_start), 32'd1);

        // Second run started at t5; assert reset at its t+2
        step(); hif.id_muldiv = 1'b0;
        #1; chk("md2_t1_busy", 32'(hif.md_busy), 32'd1);
        step(); hif.id_reads_hilo = 1'b1;
        #1; chk_stall("md2_t2_mfhi", 1'b1);
        rst = 1'b1;
        #1; chk("rstmid_busy", 32'(hif.md_busy), 32'd0);
        chk_stall("rstmid", 1'b0);
        chk("rstmid_stall_cycles", hif.stall_cycles, 32'd0);
        chk("rstmid_flush_count", hif.flush_count, 32'd0);
        step(); rst = 1'b0;
        #1; chk_stall("post_rst_mfhi", 1'b0);
        chk("post_rst_busy", 32'(hif.md_busy), 32'd0);

        // Perf: exactly one stall cycle and one flush cycle after reset
        step(); clr();
        hif.id_valid = 1'b1; hif.ex_memread = 1'b1; hif.ex_rd = 5'd8;
        hif.id_rs = 5'd8; hif.id_uses_rs = 1'b1; hif.id_branch_taken = 1'b1;
        #1; chk_stall("perf_stall", 1'b1);
        chk("perf_stall_cnt0", hif.stall_cycles, 32'd0);
        step(); hif.ex_memread = 1'b0;
        #1; chk("perf_flush", 32'(hif.ifid_flush), 32'd1);
        chk("perf_stall_cnt1", hif.stall_cycles, PERF ? 32'd1 : 32'd0);
        step(); clr();
        #1; chk("perf_flush_cnt1", hif.flush_count, PERF ? 32'd1 : 32'd0);
        chk("perf_stall_hold", hif.stall_cycles, PERF ? 32'd1 : 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Cycle budget guard
    initial begin
        #20000;
        $display("FAIL timeout: bench did not finish within budget");
        $fatal(1, "timeout");
    end

endmodule
